// File: rtl/psram_async_ctrl.sv
// psram_async_ctrl: single-word request interface to an asynchronous-mode
// cellular PSRAM. Each access holds CE_X plus WE_X or OE_X low for T_WAIT
// clocks, then keeps CE_X high for T_REC clocks before the next access.
module psram_async_ctrl #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int T_WAIT = 7,
  parameter int T_REC  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [ADDR_W-1:0] RADDR,
  input  logic [DATA_W-1:0] D_IN,
  input  logic              WE_REQ,
  input  logic              RE_REQ,
  output logic              BUSY,
  output logic [DATA_W-1:0] D_OUT,
  output logic              D_OUTEN,
  output logic              PSRAM_CLK,
  output logic              PSRAM_ADV_X,
  output logic              PSRAM_CE_X,
  output logic              PSRAM_OE_X,
  output logic              PSRAM_WE_X,
  output logic              PSRAM_LB_X,
  output logic              PSRAM_UB_X,
  inout  wire  [DATA_W-1:0] PSRAM_DATA,
  output logic [ADDR_W-1:0] PSRAM_ADDR
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RECOVER} state_t;

  // Counter reload values: a strobe phase runs from the load value down to 0.
  localparam logic [3:0] WAIT_LD = 4'(T_WAIT - 1);
  localparam logic [3:0] REC_LD  = 4'(T_REC - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                pend_q, pend_d;
  logic                ce_q, ce_d;
  logic                oe_q, oe_d;
  logic                we_q, we_d;
  logic                drv_q, drv_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_en_q, dout_en_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;

  // Next-state and output decode; every strobe is registered so the pins are glitch-free.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    pend_d    = pend_q;
    ce_d      = ce_q;
    oe_d      = oe_q;
    we_d      = we_q;
    drv_d     = drv_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    dout_en_d = 1'b0;
    wdata_d   = wdata_q;
    raddr_d   = raddr_q;
    case (state_q)
      IDLE: begin
        if (WE_REQ) begin
          // A simultaneous read is parked and issued straight after recovery.
          state_d = WRITE;
          cnt_d   = WAIT_LD;
          busy_d  = 1'b1;
          ce_d    = 1'b0;
          we_d    = 1'b0;
          drv_d   = 1'b1;
          addr_d  = WADDR;
          wdata_d = D_IN;
          pend_d  = RE_REQ;
          raddr_d = RADDR;
        end else if (RE_REQ) begin
          state_d = READ;
          cnt_d   = WAIT_LD;
          busy_d  = 1'b1;
          ce_d    = 1'b0;
          oe_d    = 1'b0;
          addr_d  = RADDR;
        end
      end
      WRITE, READ: begin
        if (cnt_q == 4'd0) begin
          // Strobes rise and the bus is released on the same edge.
          state_d = RECOVER;
          cnt_d   = REC_LD;
          ce_d    = 1'b1;
          oe_d    = 1'b1;
          we_d    = 1'b1;
          drv_d   = 1'b0;
          if (state_q == READ) begin
            dout_d    = PSRAM_DATA;
            dout_en_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == 4'd0) begin
          if (pend_q) begin
            state_d = READ;
            cnt_d   = WAIT_LD;
            pend_d  = 1'b0;
            ce_d    = 1'b0;
            oe_d    = 1'b0;
            addr_d  = raddr_q;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        drv_d   = 1'b0;
      end
    endcase
  end

  // Control and pin registers; reset forces strobes high and the bus off immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      pend_q    <= 1'b0;
      ce_q      <= 1'b1;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      drv_q     <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      ce_q      <= ce_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      drv_q     <= drv_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
    end
  end

  // Write data and parked read address are only consumed under drv_q/pend_q, so they need no reset.
  always_ff @(posedge CLK) begin
    wdata_q <= wdata_d;
    raddr_q <= raddr_d;
  end

  assign PSRAM_DATA  = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign PSRAM_CLK   = 1'b0;
  assign PSRAM_ADV_X = 1'b0;
  assign PSRAM_CE_X  = ce_q;
  assign PSRAM_OE_X  = oe_q;
  assign PSRAM_WE_X  = we_q;
  assign PSRAM_LB_X  = ce_q;
  assign PSRAM_UB_X  = ce_q;
  assign PSRAM_ADDR  = addr_q;
  assign BUSY        = busy_q;
  assign D_OUT       = dout_q;
  assign D_OUTEN     = dout_en_q;

endmodule

// File: tb/tb_psram_async_ctrl.sv
// Directed bench for psram_async_ctrl with a small behavioural async PSRAM.
module tb_psram_async_ctrl;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int TW = 7;
  localparam int TR = 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] WADDR = '0;
  logic [AW-1:0] RADDR = '0;
  logic [DW-1:0] D_IN = '0;
  logic          WE_REQ = 1'b0;
  logic          RE_REQ = 1'b0;
  logic          BUSY, D_OUTEN;
  logic [DW-1:0] D_OUT;
  logic          PSRAM_CLK, PSRAM_ADV_X, PSRAM_CE_X, PSRAM_OE_X, PSRAM_WE_X;
  logic          PSRAM_LB_X, PSRAM_UB_X;
  wire  [DW-1:0] PSRAM_DATA;
  logic [AW-1:0] PSRAM_ADDR;

  int n_chk  = 0;
  int n_fail = 0;

  psram_async_ctrl #(.ADDR_W(AW), .DATA_W(DW), .T_WAIT(TW), .T_REC(TR)) dut (
    .CLK(CLK), .RST(RST), .WADDR(WADDR), .RADDR(RADDR), .D_IN(D_IN),
    .WE_REQ(WE_REQ), .RE_REQ(RE_REQ), .BUSY(BUSY), .D_OUT(D_OUT),
    .D_OUTEN(D_OUTEN), .PSRAM_CLK(PSRAM_CLK), .PSRAM_ADV_X(PSRAM_ADV_X),
    .PSRAM_CE_X(PSRAM_CE_X), .PSRAM_OE_X(PSRAM_OE_X), .PSRAM_WE_X(PSRAM_WE_X),
    .PSRAM_LB_X(PSRAM_LB_X), .PSRAM_UB_X(PSRAM_UB_X), .PSRAM_DATA(PSRAM_DATA),
    .PSRAM_ADDR(PSRAM_ADDR)
  );

  always #5 CLK = ~CLK;

  // Behavioural PSRAM: 1K words indexed by the low address bits.
  logic [DW-1:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge CLK)
    if (!PSRAM_CE_X && !PSRAM_WE_X) mem[PSRAM_ADDR[9:0]] <= PSRAM_DATA;
  assign PSRAM_DATA = (!PSRAM_CE_X && !PSRAM_OE_X) ? mem[PSRAM_ADDR[9:0]] : {DW{1'bz}};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    WADDR = a; D_IN = d; WE_REQ = 1'b1;
    @(posedge CLK); #1; WE_REQ = 1'b0;
    for (int c = 1; c <= TW; c++) begin
      @(negedge CLK);
      chk("wr_busy", 32'(BUSY), 1);
      chk("wr_ce", 32'(PSRAM_CE_X), 0);
      chk("wr_we", 32'(PSRAM_WE_X), 0);
      chk("wr_oe", 32'(PSRAM_OE_X), 1);
      chk("wr_lbub", {30'd0, PSRAM_LB_X, PSRAM_UB_X}, 0);
      chk("wr_data", 32'(PSRAM_DATA), 32'(d));
      chk("wr_addr", 32'(PSRAM_ADDR), 32'(a));
      chk("wr_douten", 32'(D_OUTEN), 0);
      @(posedge CLK); #1;
    end
    for (int r = 1; r <= TR; r++) begin
      @(negedge CLK);
      chk("wr_rec_busy", 32'(BUSY), 1);
      chk("wr_rec_strb", {29'd0, PSRAM_CE_X, PSRAM_WE_X, PSRAM_LB_X}, 32'h7);
      chk("wr_rec_douten", 32'(D_OUTEN), 0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("wr_idle_busy", 32'(BUSY), 0);
  endtask

  task automatic read_word(input logic [AW-1:0] a, input logic [DW-1:0] exp, input bit inject);
    RADDR = a; RE_REQ = 1'b1;
    @(posedge CLK); #1; RE_REQ = 1'b0;
    for (int c = 1; c <= TW; c++) begin
      @(negedge CLK);
      chk("rd_busy", 32'(BUSY), 1);
      chk("rd_ce", 32'(PSRAM_CE_X), 0);
      chk("rd_oe", 32'(PSRAM_OE_X), 0);
      chk("rd_we", 32'(PSRAM_WE_X), 1);
      chk("rd_addr", 32'(PSRAM_ADDR), 32'(a));
      chk("rd_douten", 32'(D_OUTEN), 0);
      if (inject && c == 3) begin
        WADDR = a; D_IN = ~exp; WE_REQ = 1'b1;
      end
      @(posedge CLK); #1; WE_REQ = 1'b0;
    end
    for (int r = 1; r <= TR; r++) begin
      @(negedge CLK);
      chk("rd_rec_busy", 32'(BUSY), 1);
      chk("rd_rec_strb", {29'd0, PSRAM_CE_X, PSRAM_OE_X, PSRAM_WE_X}, 32'h7);
      chk("rd_douten", 32'(D_OUTEN), (r == 1) ? 1 : 0);
      if (r == 1) chk("rd_dout", 32'(D_OUT), 32'(exp));
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("rd_idle_busy", 32'(BUSY), 0);
    chk("rd_idle_douten", 32'(D_OUTEN), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] base;
    logic [AW-1:0] a;
    int lim;

    // Reset state.
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_strb", {27'd0, PSRAM_CE_X, PSRAM_OE_X, PSRAM_WE_X, PSRAM_LB_X, PSRAM_UB_X}, 32'h1F);
    chk("rst_dout", 32'(D_OUT), 0);
    chk("rst_douten", 32'(D_OUTEN), 0);
    chk("rst_addr", 32'(PSRAM_ADDR), 0);
    chk("rst_clk_adv", {30'd0, PSRAM_CLK, PSRAM_ADV_X}, 0);

    // Basic write then read back.
    write_word(23'h000005, 16'hA5A5);
    chk("mem_05", 32'(mem[10'h005]), 32'hA5A5);
    read_word(23'h000005, 16'hA5A5, 1'b0);
    chk("addr_hold", 32'(PSRAM_ADDR), 32'h5);

    // Simultaneous write and read to the same word.
    WADDR = 23'h10; D_IN = 16'h1234; RADDR = 23'h10;
    WE_REQ = 1'b1; RE_REQ = 1'b1;
    @(posedge CLK); #1; WE_REQ = 1'b0; RE_REQ = 1'b0;
    lim = 2 * TW + 2 * TR + 1;
    for (int c = 1; c <= lim; c++) begin
      @(negedge CLK);
      if (c <= TW) begin
        chk("wr_rd_w_busy", 32'(BUSY), 1);
        chk("wr_rd_w_strb", {29'd0, PSRAM_CE_X, PSRAM_WE_X, PSRAM_OE_X}, 32'h1);
        chk("wr_rd_w_data", 32'(PSRAM_DATA), 32'h1234);
      end else if (c <= TW + TR) begin
        chk("wr_rd_rec_busy", 32'(BUSY), 1);
        chk("wr_rd_rec_strb", {29'd0, PSRAM_CE_X, PSRAM_WE_X, PSRAM_OE_X}, 32'h7);
      end else if (c <= 2 * TW + TR) begin
        chk("wr_rd_r_busy", 32'(BUSY), 1);
        chk("wr_rd_r_strb", {29'd0, PSRAM_CE_X, PSRAM_WE_X, PSRAM_OE_X}, 32'h2);
        chk("wr_rd_r_addr", 32'(PSRAM_ADDR), 32'h10);
        chk("wr_rd_r_douten", 32'(D_OUTEN), 0);
      end else if (c <= 2 * TW + 2 * TR) begin
        chk("wr_rd_end_busy", 32'(BUSY), 1);
        chk("wr_rd_douten", 32'(D_OUTEN), (c == 2 * TW + TR + 1) ? 1 : 0);
        if (c == 2 * TW + TR + 1) chk("wr_rd_dout", 32'(D_OUT), 32'h1234);
      end else begin
        chk("wr_rd_idle_busy", 32'(BUSY), 0);
        chk("wr_rd_idle_douten", 32'(D_OUTEN), 0);
      end
      if (c < lim) begin
        @(posedge CLK); #1;
      end
    end

    // Write request while busy with a read is dropped.
    write_word(23'h000020, 16'hBEEF);
    read_word(23'h000020, 16'hBEEF, 1'b1);
    chk("drop_mem", 32'(mem[10'h020]), 32'hBEEF);
    read_word(23'h000020, 16'hBEEF, 1'b0);

    // Reset asserted in cycle 4 of a write acts without a clock edge.
    WADDR = 23'h30; D_IN = 16'h5555; WE_REQ = 1'b1;
    @(posedge CLK); #1; WE_REQ = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("mid_we_low", 32'(PSRAM_WE_X), 0);
    RST = 1'b1;
    #1;
    chk("arst_strb", {27'd0, PSRAM_CE_X, PSRAM_OE_X, PSRAM_WE_X, PSRAM_LB_X, PSRAM_UB_X}, 32'h1F);
    chk("arst_busy", 32'(BUSY), 0);
    chk("arst_addr", 32'(PSRAM_ADDR), 0);
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_busy", 32'(BUSY), 0);
    chk("post_rst_ce", 32'(PSRAM_CE_X), 1);

    // Address sweep across the top-of-range wrap.
    base = 23'h7FFFF8;
    for (int i = 0; i < 16; i++) begin
      a = base + 23'(i);
      write_word(a, 16'(a + 23'd1));
    end
    for (int i = 0; i < 16; i++) begin
      a = base + 23'(i);
      read_word(a, 16'(a + 23'd1), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
